// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: latches CMP flags, resolves B/BEQ/BGE,
// drives a registered redirect and a fixed flush window. Optional BRANCH_STATS_EN adds taken_cnt_o.
module branch_resolve_unit #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic              zero_i,
  input  logic              negative_i,
  input  logic [ADDR_W-1:0] target_i,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              z_flag_o,
  output logic              n_flag_o
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       taken_cnt_o
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [3:0] OP_CMP = 4'b0101;
  localparam logic [3:0] OP_B   = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1010;
  localparam logic [3:0] OP_BGE = 4'b1011;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               taken_q, taken_d;
  logic [ADDR_W-1:0]  target_q, target_d;
  logic               flush_q, flush_d;
  logic               busy_q, busy_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic               take_c;

  // Branch condition against the registered flags only
  always_comb begin
    take_c = 1'b0;
    unique case (op_i)
      OP_B:    take_c = 1'b1;
      OP_BEQ:  take_c = z_q;
      OP_BGE:  take_c = ~n_q;
      default: take_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    taken_d  = 1'b0;
    target_d = target_q;
    flush_d  = flush_q;
    busy_d   = busy_q;
    z_d      = z_q;
    n_d      = n_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (op_i == OP_CMP) begin
            z_d = zero_i;
            n_d = negative_i;
          end else if (take_c) begin
            taken_d  = 1'b1;
            target_d = target_i;
            flush_d  = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = FLUSH_LOAD;
            state_d  = FLUSH;
          end
        end
      end
      FLUSH: begin
        // Execute inputs are wrong-path here and deliberately ignored
        if (cnt_q == '0) begin
          flush_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      flush_q  <= flush_d;
      busy_q   <= busy_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign taken_o  = taken_q;
  assign target_o = target_q;
  assign flush_o  = flush_q;
  assign busy_o   = busy_q;
  assign z_flag_o = z_q;
  assign n_flag_o = n_q;

`ifdef BRANCH_STATS_EN
  logic [15:0] stats_q, stats_d;

  // Saturating count of cycles with taken_o high
  always_comb begin
    stats_d = stats_q;
    if (taken_q && (stats_q != 16'hFFFF)) stats_d = stats_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stats_q <= '0;
    else     stats_q <= stats_d;
  end

  assign taken_cnt_o = stats_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (covers BRANCH_STATS_EN when defined).
module tb_branch_resolve_unit;

  localparam int unsigned ADDR_W = 16;
  localparam logic [3:0] OP_CMP   = 4'b0101;
  localparam logic [3:0] OP_B     = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_BGE   = 4'b1011;
  localparam logic [3:0] OP_STALL = 4'b1100;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic [3:0]        op_i;
  logic              zero_i;
  logic              negative_i;
  logic [ADDR_W-1:0] target_i;
  logic              taken_o;
  logic [ADDR_W-1:0] target_o;
  logic              flush_o;
  logic              busy_o;
  logic              z_flag_o;
  logic              n_flag_o;
`ifdef BRANCH_STATS_EN
  logic [15:0]       taken_cnt_o;
`endif

  int n_asserts = 0;
  int n_fails   = 0;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .op_i       (op_i),
    .zero_i     (zero_i),
    .negative_i (negative_i),
    .target_i   (target_i),
    .taken_o    (taken_o),
    .target_o   (target_o),
    .flush_o    (flush_o),
    .busy_o     (busy_o),
    .z_flag_o   (z_flag_o),
    .n_flag_o   (n_flag_o)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt_o(taken_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic z, input logic n,
                       input logic [ADDR_W-1:0] tgt);
    valid_i    = v;
    op_i       = op;
    zero_i     = z;
    negative_i = n;
    target_i   = tgt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 4'h0, 1'b0, 1'b0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, '0);
    #12;
    chk("rst_taken", 32'(taken_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Idle with garbage on the don't-care inputs
    drive(1'b0, OP_B, 1'b1, 1'b1, 16'hBEEF);
    for (int i = 0; i < 5; i++) tick();
    chk("idle_taken",  32'(taken_o),  32'd0);
    chk("idle_target", 32'(target_o), 32'd0);
    chk("idle_flush",  32'(flush_o),  32'd0);
    chk("idle_busy",   32'(busy_o),   32'd0);
    chk("idle_z",      32'(z_flag_o), 32'd0);
    chk("idle_n",      32'(n_flag_o), 32'd0);

    // CMP z=1 then BEQ taken
    drive(1'b1, OP_CMP, 1'b1, 1'b0, '0); tick();
    chk("cmp1_z", 32'(z_flag_o), 32'd1);
    chk("cmp1_n", 32'(n_flag_o), 32'd0);
    chk("cmp1_taken", 32'(taken_o), 32'd0);
    drive(1'b1, OP_BEQ, 1'b0, 1'b0, 16'h0040); tick();
    chk("beq_taken",  32'(taken_o),  32'd1);
    chk("beq_target", 32'(target_o), 32'h0040);
    chk("beq_flush0", 32'(flush_o),  32'd1);
    chk("beq_busy0",  32'(busy_o),   32'd1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, '0); tick();
    chk("beq_taken1", 32'(taken_o),  32'd0);
    chk("beq_flush1", 32'(flush_o),  32'd1);
    chk("beq_busy1",  32'(busy_o),   32'd1);
    chk("beq_hold",   32'(target_o), 32'h0040);
    tick();
    chk("beq_flush2", 32'(flush_o), 32'd0);
    chk("beq_busy2",  32'(busy_o),  32'd0);

    // CMP z=0 n=1: BGE and BEQ both not taken
    drive(1'b1, OP_CMP, 1'b0, 1'b1, '0); tick();
    chk("cmp2_z", 32'(z_flag_o), 32'd0);
    chk("cmp2_n", 32'(n_flag_o), 32'd1);
    drive(1'b1, OP_BGE, 1'b0, 1'b0, 16'h0100); tick();
    chk("bge_nt_taken", 32'(taken_o), 32'd0);
    chk("bge_nt_flush", 32'(flush_o), 32'd0);
    drive(1'b1, OP_BEQ, 1'b0, 1'b0, 16'h0200); tick();
    chk("beq_nt_taken",  32'(taken_o),  32'd0);
    chk("beq_nt_flush",  32'(flush_o),  32'd0);
    chk("beq_nt_target", 32'(target_o), 32'h0040);
    // Stall and a non-branch op leave flags alone
    drive(1'b1, OP_STALL, 1'b1, 1'b0, '0); tick();
    drive(1'b1, 4'b0001, 1'b1, 1'b0, 16'h0300); tick();
    chk("stall_z", 32'(z_flag_o), 32'd0);
    chk("stall_n", 32'(n_flag_o), 32'd1);
    chk("stall_taken", 32'(taken_o), 32'd0);

    // B followed by wrong-path CMP and B
    drive(1'b1, OP_B, 1'b0, 1'b0, 16'h1234); tick();
    chk("b_taken",  32'(taken_o),  32'd1);
    chk("b_target", 32'(target_o), 32'h1234);
    drive(1'b1, OP_CMP, 1'b1, 1'b0, '0); tick();
    chk("wp_cmp_taken", 32'(taken_o),  32'd0);
    chk("wp_cmp_z",     32'(z_flag_o), 32'd0);
    chk("wp_cmp_n",     32'(n_flag_o), 32'd1);
    drive(1'b1, OP_B, 1'b0, 1'b0, 16'h0008); tick();
    chk("wp_b_taken",  32'(taken_o),  32'd0);
    chk("wp_b_flush",  32'(flush_o),  32'd0);
    chk("wp_b_busy",   32'(busy_o),   32'd0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, '0); tick();
    chk("wp_b_taken2", 32'(taken_o),  32'd0);
    chk("wp_b_target", 32'(target_o), 32'h1234);
    chk("wp_b_z",      32'(z_flag_o), 32'd0);

    // Reset in first FLUSH cycle clears everything before next edge
    drive(1'b1, OP_CMP, 1'b1, 1'b1, '0); tick();
    drive(1'b1, OP_B, 1'b0, 1'b0, 16'h00AA); tick();
    drive(1'b0, 4'h0, 1'b0, 1'b0, '0);
    chk("pre_rst_flush", 32'(flush_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_flush",  32'(flush_o),  32'd0);
    chk("mid_rst_busy",   32'(busy_o),   32'd0);
    chk("mid_rst_taken",  32'(taken_o),  32'd0);
    chk("mid_rst_target", 32'(target_o), 32'd0);
    chk("mid_rst_z",      32'(z_flag_o), 32'd0);
    chk("mid_rst_n",      32'(n_flag_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    // Flags cleared, IDLE: BGE (n=0) taken, BEQ (z=0) would not be
    drive(1'b1, OP_BEQ, 1'b0, 1'b0, 16'h0011); tick();
    chk("post_rst_beq", 32'(taken_o), 32'd0);
    drive(1'b1, OP_BGE, 1'b0, 1'b0, 16'h0022); tick();
    chk("post_rst_bge",    32'(taken_o),  32'd1);
    chk("post_rst_target", 32'(target_o), 32'h0022);
    idle(3);
    chk("post_rst_flush", 32'(flush_o), 32'd0);

`ifdef BRANCH_STATS_EN
    rst = 1'b1; #3;
    chk("stats_rst", 32'(taken_cnt_o), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, OP_B, 1'b0, 1'b0, 16'(k + 1)); tick();
      idle(3);
    end
    chk("stats_three", 32'(taken_cnt_o), 32'd3);
    force dut.stats_q = 16'hFFFF;
    tick();
    release dut.stats_q;
    chk("stats_preload", 32'(taken_cnt_o), 32'h0000FFFF);
    drive(1'b1, OP_B, 1'b0, 1'b0, 16'h0099); tick();
    idle(3);
    chk("stats_sat", 32'(taken_cnt_o), 32'h0000FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the ALU condition outputs (zero, negative).
- Latches the Z/N condition flags when a CMP retires.
- Resolves B/BEQ/BGE against the latched flags and drives a registered redirect (taken + target) to fetch.
- Issues a fixed-length flush window to squash wrong-path instructions already in the pipeline.

Parameters:
- ADDR_W, 16, width of branch target / PC.
- FLUSH_CYCLES, 2, cycles flush_o stays high after a taken branch (legal range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_i  input  1  execute-stage instruction valid this cycle.
- op_i  input  4  ALU select of the executing instruction: 0101 CMP, 1001 B, 1010 BEQ, 1011 BGE, 1100 stall; others are non-branch.
- zero_i  input  1  ALU zero output, meaningful only when op_i=0101.
- negative_i  input  1  ALU negative output, meaningful only when op_i=0101.
- target_i  input  ADDR_W  resolved branch target address.
- taken_o  output  1  one-cycle redirect pulse to fetch.
- target_o  output  ADDR_W  redirect address, valid while taken_o=1.
- flush_o  output  1  squash the instructions in the decode/execute stages.
- busy_o  output  1  high in FLUSH state; execute inputs are ignored.
- z_flag_o  output  1  latched Z flag.
- n_flag_o  output  1  latched N flag.

Behaviour:
- Reset (async assert, sync deassert): taken_o=0, target_o=0, flush_o=0, busy_o=0, z_flag_o=0, n_flag_o=0, state=IDLE, flush counter=0.
- FSM states are IDLE and FLUSH.
- IDLE, valid_i=1, op=CMP: on the clock edge z_flag_o<=zero_i and n_flag_o<=negative_i. New flags are visible to a branch in the next cycle (1-cycle flag latency).
- IDLE, valid_i=1, branch op, taken condition:
  - B: always taken.
  - BEQ: taken if z_flag_o=1.
  - BGE: taken if n_flag_o=0.
  - Conditions use the registered flags only.
- Taken branch, at the edge:
  - taken_o<=1 for exactly one cycle; target_o<=target_i.
  - flush_o<=1 and busy_o<=1; counter<=FLUSH_CYCLES-1; go to FLUSH.
  - Latency from the branch in execute to taken_o is 1 cycle.
- Not-taken branch: no outputs change; stay in IDLE.
- FLUSH: taken_o<=0 after the first cycle; target_o holds its value.
  - Each cycle: if counter=0, go to IDLE and drop flush_o/busy_o at that edge; else decrement.
  - flush_o is high for exactly FLUSH_CYCLES cycles.
- In FLUSH, valid_i is ignored: a CMP does not update the flags and a branch is not evaluated (wrong-path).
- Stall op (1100) and non-branch ops: no state change; flags hold.
- valid_i=0: op_i, zero_i, negative_i and target_i are don't-care.
- Reset asserted mid-FLUSH: all outputs clear immediately and the FSM goes to IDLE. Latched flags are lost.
- The counter never wraps: FLUSH exits at 0.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds output taken_cnt_o [15:0]:
  - Increments on every cycle taken_o is asserted.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- When not defined, the port and counter do not exist and the rest of the behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> all outputs stay 0; busy_o=0.
- CMP with zero_i=1, negative_i=0; next cycle BEQ target 16'h0040 -> taken_o pulses 1 cycle after BEQ with target_o=16'h0040; flush_o high 2 cycles; busy_o low afterwards.
- CMP zero_i=0, negative_i=1; then BGE and BEQ -> no taken_o, no flush_o; z_flag_o=0, n_flag_o=1.
- B target 16'h1234 followed on the next two cycles by CMP (zero_i=1) and B target 16'h0008 -> single taken_o for 16'h1234; the wrong-path CMP leaves the flags unchanged; the second B is not taken.
- Assert rst in the 1st FLUSH cycle -> flush_o, busy_o, taken_o, target_o and both flags go to 0 before the next edge; FSM in IDLE.
- With BRANCH_STATS_EN: 3 taken B's separated by flush windows -> taken_cnt_o=3. Preload the counter to 16'hFFFF via force, then one more taken branch -> stays at 16'hFFFF.
